// File: rtl/mem_access_stage.sv
// MIPS MEM stage: turns EX/MEM load/store control into a req/ack data-memory transaction.
// Non-memory ops pass through combinationally; memory ops stall for 1 + BUSY cycles, with a bounded wait.
module mem_access_stage #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_en_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic [WORD_LEN-1:0]     alu_result_in,
    input  logic [WORD_LEN-1:0]     st_val_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [WORD_LEN-1:0]     dmem_addr,
    output logic [WORD_LEN-1:0]     dmem_wdata,
    input  logic [WORD_LEN-1:0]     dmem_rdata,
    input  logic                    dmem_ack,
    output logic                    stall,
    output logic                    mem_err,
    output logic                    wb_en_out,
    output logic                    mem_r_en_out,
    output logic [WORD_LEN-1:0]     alu_result_out,
    output logic [WORD_LEN-1:0]     mem_data_out,
    output logic [REG_ADDR_LEN-1:0] dest_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t state_q, state_nxt;

    logic [CNT_W-1:0]        cnt_q;
    logic [WORD_LEN-1:0]     alu_q;
    logic [WORD_LEN-1:0]     wdata_q;
    logic                    we_q;
    logic                    wb_en_q;
    logic                    mem_r_en_q;
    logic [REG_ADDR_LEN-1:0] dest_q;
    logic [WORD_LEN-1:0]     rdata_q;
    logic                    err_q;

    logic access;
    logic misaligned;

    assign access     = mem_r_en_in | mem_w_en_in;
    assign misaligned = access & (alu_result_in[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_q      <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            dest_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (access && !misaligned) begin
                        alu_q      <= alu_result_in;
                        wdata_q    <= st_val_in;
                        we_q       <= mem_w_en_in;
                        wb_en_q    <= wb_en_in;
                        mem_r_en_q <= mem_r_en_in;
                        dest_q     <= dest_in;
                        cnt_q      <= '0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // An ack on the last allowed cycle wins over the timeout.
                    if (dmem_ack) begin
                        rdata_q <= we_q ? '0 : dmem_rdata;
                        err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt      = state_q;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;
        stall          = 1'b0;
        mem_err        = 1'b0;
        wb_en_out      = 1'b0;
        mem_r_en_out   = 1'b0;
        alu_result_out = '0;
        mem_data_out   = '0;
        dest_out       = '0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    alu_result_out = alu_result_in;
                    dest_out       = dest_in;
                    if (!access) begin
                        wb_en_out = wb_en_in;
                    end else if (misaligned) begin
                        // Squashed: no request, enables killed, pipeline keeps moving.
                        mem_err = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    dmem_req   = 1'b1;
                    dmem_we    = we_q;
                    dmem_addr  = alu_q;
                    dmem_wdata = wdata_q;
                    stall      = 1'b1;
                    if (dmem_ack || (cnt_q == CNT_LAST)) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    wb_en_out      = wb_en_q & ~err_q;
                    mem_r_en_out   = mem_r_en_q & ~err_q;
                    alu_result_out = alu_q;
                    dest_out       = dest_q;
                    mem_data_out   = rdata_q;
                    mem_err        = err_q;
                    state_nxt      = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: IDLE vector table plus multi-cycle load/store/timeout/reset sequences.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_result_in, st_val_in;
    logic [4:0]  dest_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall, mem_err, wb_en_out, mem_r_en_out;
    logic [31:0] alu_result_out, mem_data_out;
    logic [4:0]  dest_out;

    mem_access_stage #(.WORD_LEN(32), .REG_ADDR_LEN(5), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .mem_err(mem_err), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .alu_result_out(alu_result_out),
        .mem_data_out(mem_data_out), .dest_out(dest_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb, rd, stall, err, req, we, dc_ad;
        logic [31:0] alu, data, addr, wdata;
        logic [4:0]  dest;
    } exp_t;

    typedef struct {
        logic        wb, r, w, ack;
        logic [31:0] alu, st;
        logic [4:0]  dest;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t exp_zero();
        exp_t e;
        e.wb = 0; e.rd = 0; e.stall = 0; e.err = 0; e.req = 0; e.we = 0; e.dc_ad = 0;
        e.alu = 0; e.data = 0; e.addr = 0; e.wdata = 0; e.dest = 0;
        return e;
    endfunction

    function automatic exp_t exp_pass(logic wb, logic [31:0] alu, logic [4:0] dest);
        exp_t e;
        e = exp_zero();
        e.wb = wb; e.alu = alu; e.dest = dest;
        return e;
    endfunction

    task automatic chk(string tag, string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic compare(string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.scoreboard: got empty queue expected an entry", tag);
            return;
        end
        e = exp_q.pop_front();
        chk(tag, "wb_en_out",    {31'b0, wb_en_out},    {31'b0, e.wb});
        chk(tag, "mem_r_en_out", {31'b0, mem_r_en_out}, {31'b0, e.rd});
        chk(tag, "stall",        {31'b0, stall},        {31'b0, e.stall});
        chk(tag, "mem_err",      {31'b0, mem_err},      {31'b0, e.err});
        chk(tag, "dmem_req",     {31'b0, dmem_req},     {31'b0, e.req});
        chk(tag, "dmem_we",      {31'b0, dmem_we},      {31'b0, e.we});
        chk(tag, "dmem_addr",    dmem_addr,             e.addr);
        chk(tag, "dmem_wdata",   dmem_wdata,            e.wdata);
        // Bubble cycles leave the data fields unspecified.
        if (!e.dc_ad) begin
            chk(tag, "alu_result_out", alu_result_out,      e.alu);
            chk(tag, "dest_out",       {27'b0, dest_out},   {27'b0, e.dest});
            chk(tag, "mem_data_out",   mem_data_out,        e.data);
        end
    endtask

    task automatic drive(logic wb, logic r, logic w, logic [31:0] alu, logic [31:0] st,
                         logic [4:0] dest, logic ack, logic [31:0] rdata);
        wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
        alu_result_in = alu; st_val_in = st; dest_in = dest;
        dmem_ack = ack; dmem_rdata = rdata;
    endtask

    // One full memory access; ack_at = BUSY cycle (1-based) carrying ack, 0 = never.
    task automatic mem_op(string tag, logic is_wr, logic [31:0] addr, logic [31:0] wdata,
                          logic [31:0] rdata, logic [4:0] dest, int ack_at);
        exp_t e;
        logic ok;
        @(posedge clk); #1;
        drive(!is_wr, !is_wr, is_wr, addr, wdata, dest, 1'b0, 32'h0);
        e = exp_zero(); e.stall = 1; e.dc_ad = 1;
        exp_q.push_back(e);
        @(negedge clk); compare({tag, "_idle"});
        for (int b = 1; b <= TO; b++) begin
            @(posedge clk); #1;
            dmem_ack   = (b == ack_at);
            dmem_rdata = (b == ack_at) ? rdata : $urandom;
            e = exp_zero(); e.stall = 1; e.req = 1; e.we = is_wr;
            e.addr = addr; e.wdata = wdata; e.dc_ad = 1;
            exp_q.push_back(e);
            @(negedge clk); compare($sformatf("%s_busy%0d", tag, b));
            if (b == ack_at) break;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        dmem_rdata = $urandom;
        ok = (ack_at >= 1) && (ack_at <= TO);
        e = exp_zero();
        e.err = !ok; e.wb = !is_wr && ok; e.rd = !is_wr && ok;
        e.alu = addr; e.dest = dest;
        e.data = (ok && !is_wr) ? rdata : 32'h0;
        exp_q.push_back(e);
        @(negedge clk); compare({tag, "_done"});
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, addr ^ 32'h0000_00A5, 32'h0, dest + 5'd1, 1'b0, 32'h0);
        exp_q.push_back(exp_pass(1'b1, addr ^ 32'h0000_00A5, dest + 5'd1));
        @(negedge clk); compare({tag, "_after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        exp_t e;

        vecs[0] = '{wb:1, r:0, w:0, ack:0, alu:32'h0000_0042, st:32'h0, dest:5'd5,
                    e:exp_pass(1'b1, 32'h0000_0042, 5'd5)};
        vecs[1] = '{wb:0, r:0, w:0, ack:1, alu:32'hDEAD_BEEF, st:32'h1, dest:5'd31,
                    e:exp_pass(1'b0, 32'hDEAD_BEEF, 5'd31)};
        e = exp_zero(); e.err = 1; e.dc_ad = 1;
        vecs[2] = '{wb:1, r:1, w:0, ack:0, alu:32'h0000_0102, st:32'h0, dest:5'd3, e:e};
        vecs[3] = '{wb:1, r:0, w:0, ack:0, alu:32'h0000_0100, st:32'h0, dest:5'd9,
                    e:exp_pass(1'b1, 32'h0000_0100, 5'd9)};
        vecs[4] = '{wb:0, r:0, w:1, ack:1, alu:32'h0000_0023, st:32'hFFFF_0000, dest:5'd0, e:e};
        vecs[5] = '{wb:1, r:1, w:0, ack:0, alu:32'h8000_0001, st:32'h0, dest:5'd17, e:e};

        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd4, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        exp_q.push_back(exp_zero());
        compare("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].wb, vecs[i].r, vecs[i].w, vecs[i].alu, vecs[i].st,
                  vecs[i].dest, vecs[i].ack, 32'hBAD0_0000);
            exp_q.push_back(vecs[i].e);
            @(negedge clk); compare($sformatf("vec%0d", i));
        end

        mem_op("load",      1'b0, 32'h0000_0100, 32'h5555_AAAA, 32'hCAFE_F00D, 5'd7,  3);
        mem_op("store",     1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0BAD_BEEF, 5'd12, 1);
        mem_op("timeout",   1'b0, 32'h0000_0200, 32'h0,         32'h1111_2222, 5'd8,  0);
        mem_op("late_ack",  1'b0, 32'h0000_0204, 32'h0,         32'h3333_4444, 5'd9,  TO);
        mem_op("st_tmo",    1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 32'h0,         5'd2,  0);

        // Reset while a load is outstanding.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd6, 1'b0, 32'h0);
        @(posedge clk); #1;
        e = exp_zero(); e.stall = 1; e.req = 1; e.addr = 32'h0000_0300; e.dc_ad = 1;
        exp_q.push_back(e);
        compare("rst_pre");
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(exp_zero());
        compare("rst_busy");
        @(negedge clk);
        exp_q.push_back(exp_zero());
        compare("rst_hold");
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd10, 1'b0, 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(exp_pass(1'b1, 32'h0000_0055, 5'd10));
        compare("rst_release");
        @(negedge clk);
        exp_q.push_back(exp_pass(1'b1, 32'h0000_0055, 5'd10));
        compare("rst_idle");

        mem_op("post_rst",  1'b0, 32'h0000_0400, 32'h0, 32'h7777_8888, 5'd11, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
